imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader.sv | 204 ++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: assembles little-endian words into instruction memory and
// holds the CPU in reset until the image is complete. Optional trailing checksum: LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module imem_boot_loader #(
    parameter int ADDR_W      = 6,
    parameter int CYC_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int          TO_W      = $clog2(CYC_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(CYC_TIMEOUT - 1);
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        HDR0 = 3'd0,
        HDR1 = 3'd1,
        LOAD = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
`ifdef LOADER_CHECKSUM_EN
        , CHK = 3'd5
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t FIN = CHK;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction
`else
    localparam state_t FIN = RUN;
`endif

    state_t            state_r, state_s;
    logic [15:0]       count_r, count_s;
    logic [15:0]       hdr_count_s;
    logic [1:0]        byte_idx_r, byte_idx_s;
    logic [23:0]       buf_r, buf_s;
    logic [ADDR_W:0]   wcnt_r, wcnt_s;
    logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
    logic              xfer_s, waiting_s, timeout_s, last_word_s;
    logic              rx_ready_r, rx_ready_s;
    logic              imem_we_r, imem_we_s;
    logic [ADDR_W-1:0] imem_addr_r, imem_addr_s;
    logic [31:0]       imem_wdata_r, imem_wdata_s;
    logic              cpu_reset_r, done_r, error_r;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_r, csum_s;
`endif

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_reset  = cpu_reset_r;
    assign done       = done_r;
    assign error      = error_r;

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_s      = state_r;
        count_s      = count_r;
        byte_idx_s   = byte_idx_r;
        buf_s        = buf_r;
        wcnt_s       = wcnt_r;
        imem_we_s    = 1'b0;
        imem_addr_s  = imem_addr_r;
        imem_wdata_s = imem_wdata_r;
`ifdef LOADER_CHECKSUM_EN
        csum_s       = csum_r;
`endif
        xfer_s       = rx_valid && rx_ready_r;
        hdr_count_s  = {rx_data, count_r[7:0]};
        last_word_s  = (16'(wcnt_r) == (count_r - 16'd1));

        waiting_s = (state_r == HDR1) || (state_r == LOAD);
`ifdef LOADER_CHECKSUM_EN
        waiting_s = waiting_s || (state_r == CHK);
`endif
        // Idle counter only runs while mid-image; any transfer restarts it.
        timeout_s = waiting_s && !xfer_s && (to_cnt_r == TO_LIMIT);
        if (waiting_s && !xfer_s && !timeout_s) begin
            to_cnt_s = to_cnt_r + TO_W'(1);
        end else begin
            to_cnt_s = {TO_W{1'b0}};
        end

        case (state_r)
            HDR0: begin
                if (xfer_s) begin
                    count_s[7:0] = rx_data;
                    state_s      = HDR1;
                end else begin
                    state_s = HDR0;
                end
            end
            HDR1: begin
                if (xfer_s) begin
                    count_s[15:8] = rx_data;
                    if (hdr_count_s == 16'd0) begin
                        state_s = FIN;
                    end else if ({1'b0, hdr_count_s} > MAX_WORDS) begin
                        state_s = ERR;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = timeout_s ? ERR : HDR1;
                end
            end
            LOAD: begin
                if (xfer_s) begin
                    buf_s      = {rx_data, buf_r[23:8]};
                    byte_idx_s = byte_idx_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_s     = csum_next(csum_r, rx_data);
`endif
                    if (byte_idx_r == 2'd3) begin
                        imem_we_s    = 1'b1;
                        imem_addr_s  = wcnt_r[ADDR_W-1:0];
                        imem_wdata_s = {rx_data, buf_r};
                        wcnt_s       = wcnt_r + (ADDR_W+1)'(1);
                        state_s      = last_word_s ? FIN : LOAD;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = timeout_s ? ERR : LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer_s) begin
                    state_s = (rx_data == csum_r) ? RUN : ERR;
                end else begin
                    state_s = timeout_s ? ERR : CHK;
                end
            end
`endif
            RUN:     state_s = RUN;
            ERR:     state_s = ERR;
            default: state_s = ERR;
        endcase

        // Ready is registered, so it is derived from where the FSM is heading.
        rx_ready_s = (state_s == HDR0) || (state_s == HDR1) || (state_s == LOAD);
`ifdef LOADER_CHECKSUM_EN
        rx_ready_s = rx_ready_s || (state_s == CHK);
`endif
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= HDR0;
            count_r      <= 16'd0;
            byte_idx_r   <= 2'd0;
            buf_r        <= 24'd0;
            wcnt_r       <= {(ADDR_W+1){1'b0}};
            to_cnt_r     <= {TO_W{1'b0}};
            rx_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'd0;
            cpu_reset_r  <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
`endif
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            byte_idx_r   <= byte_idx_s;
            buf_r        <= buf_s;
            wcnt_r       <= wcnt_s;
            to_cnt_r     <= to_cnt_s;
            rx_ready_r   <= rx_ready_s;
            imem_we_r    <= imem_we_s;
            imem_addr_r  <= imem_addr_s;
            imem_wdata_r <= imem_wdata_s;
            // Status follows the current state, so release lands one cycle after the last write.
            cpu_reset_r  <= (state_r != RUN);
            done_r       <= (state_r == RUN);
            error_r      <= (state_r == ERR);
`ifdef LOADER_CHECKSUM_EN
            csum_r       <= csum_s;
`endif
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued by the stimulus
// and popped by a monitor on every imem_we pulse; status outputs checked directly.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int          vectors     = 0;
    int          miscompares = 0;
    int          writes_seen = 0;
    logic        we_prev     = 1'b0;
    logic [7:0]  csum        = 8'd0;
    logic [37:0] exp_q[$];

    imem_boot_loader #(.ADDR_W(ADDR_W), .CYC_TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (imem_we) begin
            writes_seen++;
            if (we_prev) begin
                vectors++;
                miscompares++;
                $display("FAIL we_width: got two consecutive imem_we cycles, expected one");
            end
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0d data %h, expected none", imem_addr, imem_wdata);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e[37:32]));
                check("wr_data", imem_wdata, e[31:0]);
            end
        end
        we_prev = imem_we;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int n;
        n = 0;
        if (maxgap > 0) idle($urandom_range(0, maxgap));
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("send_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [15:0] cnt, input int maxgap);
        csum = 8'd0;
        send(cnt[7:0], maxgap);
        send(cnt[15:8], maxgap);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) begin
            send(w[8*k +: 8], maxgap);
            csum = csum ^ w[8*k +: 8];
        end
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic finish_image();
`ifdef LOADER_CHECKSUM_EN
        send(csum, 0);
`endif
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        writes_seen = 0;
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        idle(2);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b1;
        check("rdy_before_rise", 32'(rx_ready), 32'd0);
        idle(1);
        check("rdy_after_rise", 32'(rx_ready), 32'd1);

        // Three-word program, valid held high.
        send_hdr(16'd3, 0);
        expect_wr(6'd0, 32'hE3A00013); send_word(32'hE3A00013, 0);
        expect_wr(6'd1, 32'hE3A01005); send_word(32'hE3A01005, 0);
        expect_wr(6'd2, 32'hE0802001); send_word(32'hE0802001, 0);
        check("t1_cpu_reset_pulse", 32'(cpu_reset), 32'd1);
        finish_image();
        idle(1);
        check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t1_done", 32'(done), 32'd1);
        check("t1_rx_ready", 32'(rx_ready), 32'd0);
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        idle(5);
        rx_valid = 1'b0;
        check("t1_writes", 32'(writes_seen), 32'd3);
        check("t1_pending", 32'(exp_q.size()), 32'd0);
        check("t1_done_hold", 32'(done), 32'd1);

        // Empty image.
        do_reset();
        send_hdr(16'd0, 0);
        finish_image();
        check("t2_cpu_reset_early", 32'(cpu_reset), 32'd1);
        idle(1);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_writes", 32'(writes_seen), 32'd0);

        // Oversized images.
        do_reset();
        send_hdr(16'h0041, 0);
        idle(3);
        check("t3_error", 32'(error), 32'd1);
        check("t3_rx_ready", 32'(rx_ready), 32'd0);
        check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_writes", 32'(writes_seen), 32'd0);
        do_reset();
        send_hdr(16'h0100, 0);
        idle(3);
        check("t3b_error", 32'(error), 32'd1);

        // Exactly full memory.
        do_reset();
        send_hdr(16'h0040, 0);
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = {8'(i), 8'h5A, 8'(255 - i), 8'(i * 7)};
            expect_wr(6'(i), w);
            send_word(w, 0);
        end
        finish_image();
        idle(1);
        check("t4_done", 32'(done), 32'd1);
        check("t4_writes", 32'(writes_seen), 32'd64);
        check("t4_pending", 32'(exp_q.size()), 32'd0);

        // Random gaps between bytes.
        do_reset();
        send_hdr(16'd2, 100);
        expect_wr(6'd0, 32'h11223344); send_word(32'h11223344, 100);
        expect_wr(6'd1, 32'hCAFEF00D); send_word(32'hCAFEF00D, 100);
        finish_image();
        idle(1);
        check("t5_done", 32'(done), 32'd1);
        check("t5_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t5_writes", 32'(writes_seen), 32'd2);

        // Idle timeout after byte 5 of the payload.
        do_reset();
        send_hdr(16'd2, 0);
        expect_wr(6'd0, 32'hDEADBEEF); send_word(32'hDEADBEEF, 0);
        send(8'h01, 0);
        idle(1100);
        check("t6_error", 32'(error), 32'd1);
        check("t6_writes", 32'(writes_seen), 32'd1);
        check("t6_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t6_rx_ready", 32'(rx_ready), 32'd0);

        // Reset mid-image, partial word discarded, fresh image loads.
        do_reset();
        send_hdr(16'd2, 0);
        expect_wr(6'd0, 32'h0BADF00D); send_word(32'h0BADF00D, 0);
        send(8'h77, 0);
        do_reset();
        check("t7_cpu_reset_re", 32'(cpu_reset), 32'd1);
        send_hdr(16'd1, 0);
        expect_wr(6'd0, 32'h87654321); send_word(32'h87654321, 0);
        finish_image();
        idle(1);
        check("t7_done", 32'(done), 32'd1);
        check("t7_pending", 32'(exp_q.size()), 32'd0);
        check("t7_writes", 32'(writes_seen), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum byte.
        do_reset();
        send_hdr(16'd1, 0);
        expect_wr(6'd0, 32'h01020304); send_word(32'h01020304, 0);
        send(csum ^ 8'hFF, 0);
        idle(2);
        check("t8_error", 32'(error), 32'd1);
        check("t8_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t8_done", 32'(done), 32'd0);
`endif

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
